lcd_bus_monitor: RTL and testbench

LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

---
 rtl/lcd_bus_pkg.sv | 70 +++++++
 rtl/lcd_bus_monitor_if.sv | 12 +
 rtl/lcd_ddram_shadow.sv | 27 ++
 rtl/lcd_bus_monitor.sv | 189 ++++++++++++++++++
 tb/tb_lcd_bus_monitor.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_bus_pkg.sv
// Shared constants, types and helpers for the HD44780 bus monitor.
// Instruction classes follow the highest set bit of an RS=0 byte.
package lcd_bus_pkg;

  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_LAST = 7'h67;

  localparam int SHADOW_DEPTH   = 32;
  localparam int DEF_E_MIN_HIGH = 10;
  localparam int DEF_CLR_BUSY   = 76000;
  localparam int DEF_CMD_BUSY   = 1850;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_FILL
  } mon_state_t;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_CLEAR,
    CLS_HOME,
    CLS_ENTRY,
    CLS_DISPLAY,
    CLS_SHIFT,
    CLS_FUNC,
    CLS_CGRAM,
    CLS_DDRAM
  } insn_class_t;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_sample_t;

  function automatic insn_class_t classify(input logic [7:0] b);
    insn_class_t cls;
    if (b[7])      cls = CLS_DDRAM;
    else if (b[6]) cls = CLS_CGRAM;
    else if (b[5]) cls = CLS_FUNC;
    else if (b[4]) cls = CLS_SHIFT;
    else if (b[3]) cls = CLS_DISPLAY;
    else if (b[2]) cls = CLS_ENTRY;
    else if (b[1]) cls = CLS_HOME;
    else if (b[0]) cls = CLS_CLEAR;
    else           cls = CLS_NOP;
    return cls;
  endfunction

  // The address counter runs line 1 then line 2 and wraps around both ends.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (a == LINE1_LAST)      n = LINE2_BASE;
      else if (a == LINE2_LAST) n = LINE1_BASE;
      else                      n = a + 7'd1;
    end else begin
      if (a == LINE1_BASE)      n = LINE2_LAST;
      else if (a == LINE2_BASE) n = LINE1_LAST;
      else                      n = a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_bus_monitor_if.sv
// Observed HD44780 pin bundle; the monitor only ever listens (slave).
interface lcd_bus_monitor_if;

  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_e);
  modport slave  (input  lcd_data, input  lcd_rs, input  lcd_rw, input  lcd_e);

endinterface

// File: rtl/lcd_ddram_shadow.sv
// 32x8 copy of the visible DDRAM characters, one write port and one
// combinational read port; reset fills every entry with a space.
module lcd_ddram_shadow
  import lcd_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [SHADOW_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SHADOW_DEPTH; i++) mem[i] <= SPACE;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus monitor: decodes strobes seen on the pins, tracks the
// controller's address counter and keeps a shadow of the two visible lines.
module lcd_bus_monitor
  import lcd_bus_pkg::*;
#(
  parameter int E_MIN_HIGH = DEF_E_MIN_HIGH,
  parameter int CLR_BUSY   = DEF_CLR_BUSY,
  parameter int CMD_BUSY   = DEF_CMD_BUSY
) (
  input  logic               clk,
  input  logic               rst,
  lcd_bus_monitor_if.slave   bus,
  input  logic               err_clr,
  input  logic [4:0]         rd_addr,
  output logic [7:0]         rd_char,
  output logic [6:0]         cursor_addr,
  output logic               display_on,
  output logic               cmd_valid,
  output logic [7:0]         cmd_byte,
  output logic               char_valid,
  output logic [7:0]         char_byte,
  output logic               busy,
  output logic [2:0]         err_flags
);

  localparam int EW       = $clog2(E_MIN_HIGH + 2);
  localparam int BUSY_MAX = (CLR_BUSY > CMD_BUSY) ? CLR_BUSY : CMD_BUSY;
  localparam int BW       = $clog2(BUSY_MAX + 2);
  localparam logic [EW-1:0] E_SAT = EW'(E_MIN_HIGH);

  bus_sample_t sync_a, sync_b, sync_prev;
  logic [EW-1:0] e_cnt;
  logic [BW-1:0] busy_cnt, busy_reload;
  mon_state_t    state, state_next;
  logic [4:0]    fill_idx;
  logic          dec_rs;
  logic [7:0]    dec_byte;
  insn_class_t   dec_class;
  logic          inc_mode;
  logic          cgram_mode;

  logic strobe, err_short, err_rw, err_busy, accept;
  logic       sh_we;
  logic [4:0] sh_addr;
  logic [7:0] sh_data;

  // Pins are asynchronous to clk; sync_prev is the cycle before sync_b,
  // so at a strobe it still holds the last E-high sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a    <= '0;
      sync_b    <= '0;
      sync_prev <= '0;
    end else begin
      sync_a    <= {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data};
      sync_b    <= sync_a;
      sync_prev <= sync_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 e_cnt <= '0;
    else if (!sync_b.e)      e_cnt <= '0;
    else if (e_cnt != E_SAT) e_cnt <= e_cnt + EW'(1);
  end

  assign strobe    = sync_prev.e && !sync_b.e;
  assign err_short = strobe && (e_cnt < E_SAT);
  assign err_rw    = strobe && sync_prev.rw;
  assign err_busy  = strobe && (busy || state != ST_IDLE);
  assign accept    = strobe && !err_short && !err_rw && !err_busy;

  always_comb begin
    busy_reload = BW'(CMD_BUSY);
    if (!sync_prev.rs && (classify(sync_prev.data) inside {CLS_CLEAR, CLS_HOME}))
      busy_reload = BW'(CLR_BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid  <= 1'b0;
      char_valid <= 1'b0;
      cmd_byte   <= '0;
      char_byte  <= '0;
      dec_rs     <= 1'b0;
      dec_byte   <= '0;
      busy_cnt   <= '0;
      err_flags  <= '0;
    end else begin
      cmd_valid  <= accept && !sync_prev.rs;
      char_valid <= accept && sync_prev.rs;
      if (accept && !sync_prev.rs) cmd_byte  <= sync_prev.data;
      if (accept && sync_prev.rs)  char_byte <= sync_prev.data;
      if (accept) begin
        dec_rs   <= sync_prev.rs;
        dec_byte <= sync_prev.data;
        busy_cnt <= busy_reload;
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - BW'(1);
      end
      // A fresh error event overrides a clear arriving in the same cycle.
      err_flags <= (err_clr ? 3'b000 : err_flags) | {err_busy, err_rw, err_short};
    end
  end

  assign busy      = (busy_cnt != '0);
  assign dec_class = classify(dec_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (accept) state_next = ST_DECODE;
      ST_DECODE: state_next = (!dec_rs && dec_byte == 8'h01) ? ST_FILL : ST_IDLE;
      ST_FILL:   if (fill_idx == 5'(SHADOW_DEPTH - 1)) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  fill_idx <= '0;
    else if (state != ST_FILL) fill_idx <= '0;
    else                      fill_idx <= fill_idx + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_addr <= LINE1_BASE;
      inc_mode    <= 1'b1;
      cgram_mode  <= 1'b0;
      display_on  <= 1'b0;
    end else if (state == ST_DECODE) begin
      if (dec_rs) begin
        if (!cgram_mode) cursor_addr <= step_addr(cursor_addr, inc_mode);
      end else begin
        unique case (dec_class)
          CLS_CLEAR: begin
            cursor_addr <= LINE1_BASE;
            inc_mode    <= 1'b1;
          end
          CLS_HOME:    cursor_addr <= LINE1_BASE;
          CLS_ENTRY:   inc_mode    <= dec_byte[1];
          CLS_DISPLAY: display_on  <= dec_byte[2];
          CLS_SHIFT:   if (!dec_byte[3]) cursor_addr <= step_addr(cursor_addr, dec_byte[2]);
          CLS_CGRAM:   cgram_mode  <= 1'b1;
          CLS_DDRAM: begin
            cursor_addr <= dec_byte[6:0];
            cgram_mode  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Only the first 16 cells of each line are mirrored.
  always_comb begin
    sh_we   = 1'b0;
    sh_addr = fill_idx;
    sh_data = SPACE;
    if (state == ST_FILL) begin
      sh_we = 1'b1;
    end else if (state == ST_DECODE && dec_rs && !cgram_mode) begin
      sh_data = dec_byte;
      if (cursor_addr[6:4] == LINE1_BASE[6:4]) begin
        sh_we   = 1'b1;
        sh_addr = {1'b0, cursor_addr[3:0]};
      end else if (cursor_addr[6:4] == LINE2_BASE[6:4]) begin
        sh_we   = 1'b1;
        sh_addr = {1'b1, cursor_addr[3:0]};
      end
    end
  end

  lcd_ddram_shadow u_shadow (
    .clk     (clk),
    .rst     (rst),
    .we      (sh_we),
    .wr_addr (sh_addr),
    .wr_data (sh_data),
    .rd_addr (rd_addr),
    .rd_data (rd_char)
  );

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor with shortened busy windows
// (clear/home 200 cycles, others 40) so the run stays short.
module tb_lcd_bus_monitor;

  localparam int CLR_B = 200;
  localparam int CMD_B = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_clr;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       display_on;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       char_valid;
  logic [7:0] char_byte;
  logic       busy;
  logic [2:0] err_flags;

  int checks = 0;
  int errors = 0;
  int cmd_pulses = 0;
  int char_pulses = 0;

  lcd_bus_monitor_if bus ();

  lcd_bus_monitor #(
    .E_MIN_HIGH (10),
    .CLR_BUSY   (CLR_B),
    .CMD_BUSY   (CMD_B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_clr     (err_clr),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .cursor_addr (cursor_addr),
    .display_on  (display_on),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .char_valid  (char_valid),
    .char_byte   (char_byte),
    .busy        (busy),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid === 1'b1)  cmd_pulses++;
    if (char_valid === 1'b1) char_pulses++;
  end

  // Returns on the negedge two cycles after E falls; the valid pulse
  // appears at the next posedge.
  task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d, input int hi);
    @(negedge clk);
    bus.lcd_rs   = rs;
    bus.lcd_rw   = rw;
    bus.lcd_data = d;
    @(negedge clk);
    bus.lcd_e = 1'b1;
    repeat (hi) @(negedge clk);
    bus.lcd_e = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle_timeout: busy=%0b required 0", tag, busy);
    end
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bus_write(1'b0, 1'b0, b, 12);
    wait_idle("cmd");
  endtask

  task automatic send_data(input logic [7:0] b);
    bus_write(1'b1, 1'b0, b, 12);
    wait_idle("data");
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    err_clr = 1'b0;
    rd_addr = '0;
    bus.lcd_e = 1'b0;
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0;
    bus.lcd_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("[TB] FAIL reset_cursor: got %h want 00", cursor_addr); end
    checks++; if (display_on !== 1'b0) begin errors++; $display("[TB] FAIL reset_display_on: got %b want 0", display_on); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err_flags !== 3'b000) begin errors++; $display("[TB] FAIL reset_err: got %b want 000", err_flags); end
    checks++; if ({cmd_valid, char_valid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_valid: got %b want 00", {cmd_valid, char_valid}); end
    checks++; if ({cmd_byte, char_byte} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bytes: got %h want 0000", {cmd_byte, char_byte}); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      if (rd_char !== 8'h20) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL reset_shadow: %0d entries differ, want 0", bad); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init_sequence();
    int c0, d0;
    c0 = cmd_pulses;
    d0 = char_pulses;
    bus_write(1'b0, 1'b0, 8'h38, 12);
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL init_latency: cmd_valid=%b want 1", cmd_valid); end
    checks++; if (cmd_byte !== 8'h38) begin errors++; $display("[TB] FAIL init_cmd_byte: got %h want 38", cmd_byte); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL init_busy: got %b want 1", busy); end
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL init_pulse_width: cmd_valid=%b want 0", cmd_valid); end
    wait_idle("init");
    send_cmd(8'h0C);
    send_cmd(8'h06);
    send_cmd(8'h80);
    send_data(8'h51);
    send_cmd(8'hCF);
    send_data(8'h5A);
    rd_addr = 5'd31; #1;
    checks++; if (rd_char !== 8'h5A) begin errors++; $display("[TB] FAIL init_line2_last: got %h want 5a", rd_char); end
    rd_addr = 5'd0;
    bus_write(1'b0, 1'b0, 8'h01, 12);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rd_char !== 8'h51) begin errors++; $display("[TB] FAIL fill_not_started: got %h want 51", rd_char); end
    @(posedge clk); #1;
    checks++; if (rd_char !== 8'h20) begin errors++; $display("[TB] FAIL fill_first: got %h want 20", rd_char); end
    rd_addr = 5'd31;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (rd_char !== 8'h5A) begin errors++; $display("[TB] FAIL fill_last_early: got %h want 5a", rd_char); end
    @(posedge clk); #1;
    checks++; if (rd_char !== 8'h20) begin errors++; $display("[TB] FAIL fill_last: got %h want 20", rd_char); end
    wait_idle("clear");
    checks++; if (cmd_pulses - c0 != 6) begin errors++; $display("[TB] FAIL init_cmd_count: got %0d want 6", cmd_pulses - c0); end
    checks++; if (char_pulses - d0 != 2) begin errors++; $display("[TB] FAIL init_char_count: got %0d want 2", char_pulses - d0); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL init_display_on: got %b want 1", display_on); end
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("[TB] FAIL clear_cursor: got %h want 00", cursor_addr); end
    checks++; if (err_flags !== 3'b000) begin errors++; $display("[TB] FAIL init_err: got %b want 000", err_flags); end
  endtask

  task automatic test_write_line1();
    send_cmd(8'h80);
    send_data(8'h48);
    send_data(8'h49);
    rd_addr = 5'd0; #1;
    checks++; if (rd_char !== 8'h48) begin errors++; $display("[TB] FAIL line1_h: got %h want 48", rd_char); end
    rd_addr = 5'd1; #1;
    checks++; if (rd_char !== 8'h49) begin errors++; $display("[TB] FAIL line1_i: got %h want 49", rd_char); end
    checks++; if (cursor_addr !== 7'h02) begin errors++; $display("[TB] FAIL line1_cursor: got %h want 02", cursor_addr); end
    checks++; if (char_byte !== 8'h49) begin errors++; $display("[TB] FAIL line1_char_byte: got %h want 49", char_byte); end
  endtask

  task automatic test_line_wrap();
    int bad;
    send_cmd(8'hA7);
    send_data(8'h41);
    checks++; if (cursor_addr !== 7'h40) begin errors++; $display("[TB] FAIL wrap_27_to_40: got %h want 40", cursor_addr); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      if (rd_char === 8'h41) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL wrap_not_stored: %0d entries hold 41, want 0", bad); end
    send_data(8'h42);
    rd_addr = 5'd16; #1;
    checks++; if (rd_char !== 8'h42) begin errors++; $display("[TB] FAIL wrap_line2_store: got %h want 42", rd_char); end
    checks++; if (cursor_addr !== 7'h41) begin errors++; $display("[TB] FAIL wrap_cursor_41: got %h want 41", cursor_addr); end
    send_cmd(8'h04);
    send_cmd(8'h80);
    send_data(8'h55);
    rd_addr = 5'd0; #1;
    checks++; if (rd_char !== 8'h55) begin errors++; $display("[TB] FAIL dec_store: got %h want 55", rd_char); end
    checks++; if (cursor_addr !== 7'h67) begin errors++; $display("[TB] FAIL wrap_00_to_67: got %h want 67", cursor_addr); end
    send_cmd(8'h14);
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("[TB] FAIL shift_67_to_00: got %h want 00", cursor_addr); end
    send_cmd(8'h10);
    checks++; if (cursor_addr !== 7'h67) begin errors++; $display("[TB] FAIL shift_00_to_67: got %h want 67", cursor_addr); end
    send_cmd(8'hC0);
    send_cmd(8'h10);
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("[TB] FAIL shift_40_to_27: got %h want 27", cursor_addr); end
    send_cmd(8'h18);
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("[TB] FAIL display_shift_ignored: got %h want 27", cursor_addr); end
    send_cmd(8'h06);
  endtask

  task automatic test_cgram();
    int d0, bad;
    send_cmd(8'h40);
    d0 = char_pulses;
    send_data(8'h77);
    checks++; if (char_pulses - d0 != 1) begin errors++; $display("[TB] FAIL cgram_pulse: got %0d want 1", char_pulses - d0); end
    checks++; if (char_byte !== 8'h77) begin errors++; $display("[TB] FAIL cgram_char_byte: got %h want 77", char_byte); end
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("[TB] FAIL cgram_cursor: got %h want 27", cursor_addr); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      if (rd_char === 8'h77) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL cgram_shadow: %0d entries hold 77, want 0", bad); end
    send_cmd(8'h80);
    send_data(8'h58);
    rd_addr = 5'd0; #1;
    checks++; if (rd_char !== 8'h58) begin errors++; $display("[TB] FAIL ddram_after_cgram: got %h want 58", rd_char); end
  endtask

  task automatic test_busy_error();
    int c0;
    c0 = cmd_pulses;
    bus_write(1'b0, 1'b0, 8'h01, 12);
    repeat (85) @(negedge clk);
    bus_write(1'b0, 1'b0, 8'h08, 12);
    @(posedge clk); #1;
    checks++; if (err_flags !== 3'b100) begin errors++; $display("[TB] FAIL busy_err_flag: got %b want 100", err_flags); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_dropped_pulse: got %b want 0", cmd_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_window: got %b want 1", busy); end
    wait_idle("busy");
    checks++; if (cmd_pulses - c0 != 1) begin errors++; $display("[TB] FAIL busy_cmd_count: got %0d want 1", cmd_pulses - c0); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL busy_dropped_effect: got %b want 1", display_on); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    checks++; if (err_flags !== 3'b000) begin errors++; $display("[TB] FAIL err_clr: got %b want 000", err_flags); end
  endtask

  task automatic test_short_and_rw();
    int c0;
    c0 = cmd_pulses;
    bus_write(1'b0, 1'b0, 8'h08, 4);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_flags !== 3'b001) begin errors++; $display("[TB] FAIL short_e_flag: got %b want 001", err_flags); end
    checks++; if (cmd_pulses != c0) begin errors++; $display("[TB] FAIL short_e_pulse: got %0d want 0", cmd_pulses - c0); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL short_e_effect: got %b want 1", display_on); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk);
    checks++; if (err_flags !== 3'b000) begin errors++; $display("[TB] FAIL short_clear: got %b want 000", err_flags); end
    bus_write(1'b0, 1'b0, 8'h08, 9);
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (err_flags !== 3'b001) begin errors++; $display("[TB] FAIL err_beats_clr: got %b want 001", err_flags); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    bus_write(1'b0, 1'b0, 8'h08, 10);
    wait_idle("emin");
    checks++; if (display_on !== 1'b0) begin errors++; $display("[TB] FAIL e_min_accepted: got %b want 0", display_on); end
    checks++; if (err_flags !== 3'b000) begin errors++; $display("[TB] FAIL e_min_no_err: got %b want 000", err_flags); end
    send_cmd(8'h0C);
    c0 = cmd_pulses;
    bus_write(1'b0, 1'b1, 8'h08, 12);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_flags !== 3'b010) begin errors++; $display("[TB] FAIL rw_flag: got %b want 010", err_flags); end
    checks++; if (cmd_pulses != c0) begin errors++; $display("[TB] FAIL rw_pulse: got %0d want 0", cmd_pulses - c0); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL rw_effect: got %b want 1", display_on); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    bus.lcd_rw = 1'b0;
  endtask

  task automatic test_reset_during_fill();
    int bad;
    send_cmd(8'h80);
    send_data(8'h41);
    send_cmd(8'hCF);
    send_data(8'h5A);
    rd_addr = 5'd31;
    bus_write(1'b0, 1'b0, 8'h01, 12);
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1;
    checks++; if (rd_char !== 8'h5A) begin errors++; $display("[TB] FAIL fill_mid_last: got %h want 5a", rd_char); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (rd_char !== 8'h20) begin errors++; $display("[TB] FAIL rst_fill_last: got %h want 20", rd_char); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_fill_busy: got %b want 0", busy); end
    checks++; if (display_on !== 1'b0) begin errors++; $display("[TB] FAIL rst_fill_display: got %b want 0", display_on); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      if (rd_char !== 8'h20) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rst_fill_shadow: %0d entries differ, want 0", bad); end
    @(negedge clk);
    rst = 1'b0;
    bus_write(1'b0, 1'b0, 8'h0C, 12);
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_fill_idle_accept: got %b want 1", cmd_valid); end
    checks++; if (err_flags !== 3'b000) begin errors++; $display("[TB] FAIL rst_fill_err: got %b want 000", err_flags); end
    wait_idle("post_rst");
    checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL rst_fill_decode: got %b want 1", display_on); end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_write_line1();
    test_line_wrap();
    test_cgram();
    test_busy_error();
    test_short_and_rw();
    test_reset_during_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
